// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-field positions and constants
// used by the decode-side operand logic.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;

    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 24;
    localparam int RS2_LSB = 20;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 7;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/operand_fwd_mux.sv
// Priority bypass mux for one source operand: x0, then EX, MEM, WB,
// and finally the regfile read data.
module operand_fwd_mux
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  ex_fwd,
    input  logic [REG_ADDR_W-1:0] ex_waddr,
    input  logic [DATA_WIDTH-1:0] ex_result,
    input  logic                  mem_fwd,
    input  logic [REG_ADDR_W-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  wb_wen,
    input  logic [REG_ADDR_W-1:0] wb_waddr,
    input  logic [DATA_WIDTH-1:0] wb_wdata,
    output logic [DATA_WIDTH-1:0] operand
);

    always_comb begin
        operand = rdata;
        if (rs == '0)
            operand = '0;
        else if (ex_fwd && ex_waddr == rs)
            operand = ex_result;
        else if (mem_fwd && mem_waddr == rs)
            operand = mem_wdata;
        // regfile writes at the same edge, so its read data is still stale
        else if (wb_wen && wb_waddr == rs)
            operand = wb_wdata;
    end

endmodule

// File: rtl/id_operand_stage.sv
// Decode operand stage: regfile addressing, bypass merge, load-use
// bubble insertion and the ID/EX register with valid/ready handshake.
module id_operand_stage
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  if_valid,
    input  logic [PC_WIDTH-1:0]   if_pc,
    input  logic [31:0]           if_inst,
    output logic                  id_ready,
    output logic [REG_ADDR_W-1:0] raddr1,
    output logic [REG_ADDR_W-1:0] raddr2,
    input  logic [DATA_WIDTH-1:0] rdata1,
    input  logic [DATA_WIDTH-1:0] rdata2,
    input  logic                  ex_valid,
    input  logic                  ex_wen,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_waddr,
    input  logic [DATA_WIDTH-1:0] ex_result,
    input  logic                  mem_valid,
    input  logic                  mem_wen,
    input  logic [REG_ADDR_W-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  wb_wen,
    input  logic [REG_ADDR_W-1:0] wb_waddr,
    input  logic [DATA_WIDTH-1:0] wb_wdata,
    input  logic                  flush,
    input  logic                  ex_ready,
    output logic                  id_ex_valid,
    output logic [PC_WIDTH-1:0]   id_ex_pc,
    output logic [31:0]           id_ex_inst,
    output logic [REG_ADDR_W-1:0] id_ex_rd,
    output logic [DATA_WIDTH-1:0] id_ex_op1,
    output logic [DATA_WIDTH-1:0] id_ex_op2,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic                  ex_fwd;
    logic                  mem_fwd;
    logic                  hazard;
    logic                  advance;

    assign rs1 = if_inst[RS1_MSB:RS1_LSB];
    assign rs2 = if_inst[RS2_MSB:RS2_LSB];
    assign rd  = if_inst[RD_MSB:RD_LSB];

    assign raddr1 = rs1;
    assign raddr2 = rs2;

    assign ex_fwd  = ex_valid & ex_wen;
    assign mem_fwd = mem_valid & mem_wen;

    operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd1 (
        .rs        (rs1),
        .rdata     (rdata1),
        .ex_fwd    (ex_fwd),
        .ex_waddr  (ex_waddr),
        .ex_result (ex_result),
        .mem_fwd   (mem_fwd),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .wb_wen    (wb_wen),
        .wb_waddr  (wb_waddr),
        .wb_wdata  (wb_wdata),
        .operand   (op1)
    );

    operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd2 (
        .rs        (rs2),
        .rdata     (rdata2),
        .ex_fwd    (ex_fwd),
        .ex_waddr  (ex_waddr),
        .ex_result (ex_result),
        .mem_fwd   (mem_fwd),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .wb_wen    (wb_wen),
        .wb_waddr  (wb_waddr),
        .wb_wdata  (wb_wdata),
        .operand   (op2)
    );

    // both source fields are treated as used regardless of opcode
    assign hazard = if_valid & ex_fwd & ex_is_load & (ex_waddr != '0)
                  & ((ex_waddr == rs1) | (ex_waddr == rs2));

    assign advance  = ~id_ex_valid | ex_ready;
    assign id_ready = flush | (advance & ~hazard);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            id_ex_valid <= 1'b0;
            id_ex_pc    <= '0;
            id_ex_inst  <= '0;
            id_ex_rd    <= '0;
            id_ex_op1   <= '0;
            id_ex_op2   <= '0;
            stall_cnt   <= '0;
        end else if (flush) begin
            id_ex_valid <= 1'b0;
        end else if (advance && hazard) begin
            id_ex_valid <= 1'b0;
            if (stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end else if (advance) begin
            id_ex_valid <= if_valid;
            if (if_valid) begin
                id_ex_pc   <= if_pc;
                id_ex_inst <= if_inst;
                id_ex_rd   <= rd;
                id_ex_op1  <= op1;
                id_ex_op2  <= op2;
            end
        end
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios plus
// randomized traffic against a behavioural pipeline model.
module tb_id_operand_stage;

    localparam int DW = 32;
    localparam int PW = 32;
    localparam int CW = 4;
    localparam int CNT_MAX = 15;

    logic          sys_clk;
    logic          sys_rst_n;
    logic          if_valid;
    logic [PW-1:0] if_pc;
    logic [31:0]   if_inst;
    logic          id_ready;
    logic [4:0]    raddr1;
    logic [4:0]    raddr2;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic          ex_valid;
    logic          ex_wen;
    logic          ex_is_load;
    logic [4:0]    ex_waddr;
    logic [DW-1:0] ex_result;
    logic          mem_valid;
    logic          mem_wen;
    logic [4:0]    mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          wb_wen;
    logic [4:0]    wb_waddr;
    logic [DW-1:0] wb_wdata;
    logic          flush;
    logic          ex_ready;
    logic          id_ex_valid;
    logic [PW-1:0] id_ex_pc;
    logic [31:0]   id_ex_inst;
    logic [4:0]    id_ex_rd;
    logic [DW-1:0] id_ex_op1;
    logic [DW-1:0] id_ex_op2;
    logic [CW-1:0] stall_cnt;

    logic [DW-1:0] rf [32];

    assign rdata1 = rf[raddr1];
    assign rdata2 = rf[raddr2];

    id_operand_stage #(
        .DATA_WIDTH (DW),
        .PC_WIDTH   (PW),
        .CNT_WIDTH  (CW)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .id_ready    (id_ready),
        .raddr1      (raddr1),
        .raddr2      (raddr2),
        .rdata1      (rdata1),
        .rdata2      (rdata2),
        .ex_valid    (ex_valid),
        .ex_wen      (ex_wen),
        .ex_is_load  (ex_is_load),
        .ex_waddr    (ex_waddr),
        .ex_result   (ex_result),
        .mem_valid   (mem_valid),
        .mem_wen     (mem_wen),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .wb_wen      (wb_wen),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .flush       (flush),
        .ex_ready    (ex_ready),
        .id_ex_valid (id_ex_valid),
        .id_ex_pc    (id_ex_pc),
        .id_ex_inst  (id_ex_inst),
        .id_ex_rd    (id_ex_rd),
        .id_ex_op1   (id_ex_op1),
        .id_ex_op2   (id_ex_op2),
        .stall_cnt   (stall_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model state: what EX should see after each edge
    logic          m_valid;
    logic [PW-1:0] m_pc;
    logic [31:0]   m_inst;
    logic [4:0]    m_rd;
    logic [DW-1:0] m_op1;
    logic [DW-1:0] m_op2;
    int            m_cnt;

    function automatic logic [31:0] rtype(input int rd, input int s1,
                                          input int s2);
        logic [4:0] a, b, c;
        a = 5'(rd);
        b = 5'(s1);
        c = 5'(s2);
        return {7'd0, c, b, 3'd0, a, 7'h33};
    endfunction

    // architectural value of register r as seen by the instruction in ID
    function automatic logic [DW-1:0] value_of(input int r);
        if (r == 0) return '0;
        if (ex_valid && ex_wen && int'(ex_waddr) == r) return ex_result;
        if (mem_valid && mem_wen && int'(mem_waddr) == r) return mem_wdata;
        if (wb_wen && int'(wb_waddr) == r) return wb_wdata;
        return rf[r];
    endfunction

    function automatic bit load_use(input int s1, input int s2);
        int w;
        w = int'(ex_waddr);
        return if_valid && ex_valid && ex_is_load && ex_wen && w != 0
            && (w == s1 || w == s2);
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_pc    = '0;
        m_inst  = '0;
        m_rd    = '0;
        m_op1   = '0;
        m_op2   = '0;
        m_cnt   = 0;
    endtask

    task automatic check_regs(input string p);
        chk({p, "_valid"}, 64'(id_ex_valid), 64'(m_valid));
        chk({p, "_pc"},    64'(id_ex_pc),    64'(m_pc));
        chk({p, "_inst"},  64'(id_ex_inst),  64'(m_inst));
        chk({p, "_rd"},    64'(id_ex_rd),    64'(m_rd));
        chk({p, "_op1"},   64'(id_ex_op1),   64'(m_op1));
        chk({p, "_op2"},   64'(id_ex_op2),   64'(m_op2));
        chk({p, "_cnt"},   64'(stall_cnt),   64'(m_cnt));
    endtask

    // one clock: check combinational outputs, step model, check registers
    task automatic cycle(input string p);
        int  s1, s2;
        bit  haz, can_move, rdy;
        s1 = int'(if_inst[19:15]);
        s2 = int'(if_inst[24:20]);
        #1;
        haz      = load_use(s1, s2);
        can_move = !m_valid || ex_ready;
        rdy      = flush || (can_move && !haz);
        chk({p, "_raddr1"}, 64'(raddr1), 64'(s1));
        chk({p, "_raddr2"}, 64'(raddr2), 64'(s2));
        chk({p, "_ready"},  64'(id_ready), 64'(rdy));
        if (flush) begin
            m_valid = 0;
        end else if (can_move && haz) begin
            m_valid = 0;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else if (can_move) begin
            m_valid = if_valid;
            if (if_valid) begin
                m_pc   = if_pc;
                m_inst = if_inst;
                m_rd   = if_inst[11:7];
                m_op1  = value_of(s1);
                m_op2  = value_of(s2);
            end
        end
        @(posedge sys_clk);
        #1;
        check_regs(p);
    endtask

    task automatic no_bypass();
        ex_valid   = 0;
        ex_wen     = 0;
        ex_is_load = 0;
        ex_waddr   = '0;
        ex_result  = '0;
        mem_valid  = 0;
        mem_wen    = 0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        wb_wen     = 0;
        wb_waddr   = '0;
        wb_wdata   = '0;
    endtask

    logic [31:0]   s_inst;
    logic [DW-1:0] s_op1;
    int            s_cnt;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        sys_rst_n = 0;
        if_valid  = 0;
        if_pc     = '0;
        if_inst   = '0;
        flush     = 0;
        ex_ready  = 1;
        no_bypass();
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        check_regs("reset");
        sys_rst_n = 1;

        // regfile-only read
        rf[5]    = 32'h11;
        if_valid = 1;
        if_pc    = 32'h100;
        if_inst  = rtype(3, 5, 0);
        cycle("rf");
        chk("rf_op1_const", 64'(id_ex_op1), 64'h11);
        chk("rf_op2_const", 64'(id_ex_op2), 64'h0);

        // bypass priority EX > MEM > WB
        if_pc     = 32'h104;
        if_inst   = rtype(8, 7, 0);
        ex_valid  = 1;
        ex_wen    = 1;
        ex_waddr  = 7;
        ex_result = 32'hA;
        mem_valid = 1;
        mem_wen   = 1;
        mem_waddr = 7;
        mem_wdata = 32'hB;
        wb_wen    = 1;
        wb_waddr  = 7;
        wb_wdata  = 32'hC;
        cycle("byp_ex");
        chk("byp_ex_const", 64'(id_ex_op1), 64'hA);
        ex_valid = 0;
        cycle("byp_mem");
        chk("byp_mem_const", 64'(id_ex_op1), 64'hB);
        mem_valid = 0;
        cycle("byp_wb");
        chk("byp_wb_const", 64'(id_ex_op1), 64'hC);

        // x0 is never forwarded
        no_bypass();
        rf[0]     = 32'hDEAD;
        if_inst   = rtype(9, 0, 0);
        ex_valid  = 1;
        ex_wen    = 1;
        ex_waddr  = 0;
        ex_result = 32'hFF;
        cycle("x0");
        chk("x0_const", 64'(id_ex_op1), 64'h0);

        // load-use: one bubble, then MEM forwarding
        no_bypass();
        if_pc      = 32'h200;
        if_inst    = rtype(6, 4, 4);
        ex_valid   = 1;
        ex_wen     = 1;
        ex_is_load = 1;
        ex_waddr   = 4;
        cycle("ldu1");
        chk("ldu1_valid_const", 64'(id_ex_valid), 64'h0);
        chk("ldu1_cnt_const", 64'(stall_cnt), 64'h1);
        no_bypass();
        mem_valid = 1;
        mem_wen   = 1;
        mem_waddr = 4;
        mem_wdata = 32'h55;
        cycle("ldu2");
        chk("ldu2_op1_const", 64'(id_ex_op1), 64'h55);
        chk("ldu2_op2_const", 64'(id_ex_op2), 64'h55);
        chk("ldu2_valid_const", 64'(id_ex_valid), 64'h1);

        // backpressure holds the ID/EX register
        no_bypass();
        s_inst   = id_ex_inst;
        s_op1    = id_ex_op1;
        ex_ready = 0;
        if_pc    = 32'h300;
        if_inst  = rtype(10, 11, 12);
        for (int k = 0; k < 3; k++) begin
            cycle("bp");
            chk("bp_hold_inst", 64'(id_ex_inst), 64'(s_inst));
            chk("bp_hold_op1", 64'(id_ex_op1), 64'(s_op1));
        end
        ex_ready = 1;
        cycle("bp_go");
        chk("bp_go_inst", 64'(id_ex_inst), 64'(rtype(10, 11, 12)));

        // flush wins over a load-use hazard
        s_cnt      = int'(stall_cnt);
        if_inst    = rtype(6, 4, 1);
        ex_valid   = 1;
        ex_wen     = 1;
        ex_is_load = 1;
        ex_waddr   = 4;
        flush      = 1;
        cycle("flh");
        chk("flh_cnt_const", 64'(stall_cnt), 64'(s_cnt));
        flush = 0;

        // randomized traffic with a mid-stream reset pulse
        for (int it = 0; it < 3000; it++) begin
            if (it == 1500) begin
                sys_rst_n = 0;
                #1;
                model_reset();
                check_regs("arst");
                #1;
                sys_rst_n = 1;
            end
            if ($urandom_range(0, 3) == 0)
                rf[$urandom_range(0, 31)] = $urandom;
            if_valid = ($urandom_range(0, 4) != 0);
            if_pc    = $urandom;
            if_inst  = $urandom;
            if_inst[19:15] = 5'($urandom_range(0, 3));
            if_inst[24:20] = 5'($urandom_range(0, 3));
            ex_valid   = $urandom_range(0, 1) == 1;
            ex_wen     = $urandom_range(0, 3) != 0;
            ex_is_load = $urandom_range(0, 1) == 1;
            ex_waddr   = 5'($urandom_range(0, 3));
            ex_result  = $urandom;
            mem_valid  = $urandom_range(0, 1) == 1;
            mem_wen    = $urandom_range(0, 3) != 0;
            mem_waddr  = 5'($urandom_range(0, 3));
            mem_wdata  = $urandom;
            wb_wen     = $urandom_range(0, 1) == 1;
            wb_waddr   = 5'($urandom_range(0, 3));
            wb_wdata   = $urandom;
            flush      = $urandom_range(0, 7) == 0;
            ex_ready   = $urandom_range(0, 3) != 0;
            cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
Decode-side operand stage that sits directly upstream of the register file and feeds the EX stage.
- Extracts source and destination register fields from the fetched instruction.
- Drives the regfile read addresses and merges the read data with EX/MEM/WB bypass values.
- Detects load-use hazards and inserts bubbles.
- Holds the ID/EX pipeline register under a valid/ready handshake with flush support.

Parameters:
DATA_WIDTH, 32, operand / regfile data width
PC_WIDTH, 32, program counter width
CNT_WIDTH, 16, width of load-use stall performance counter

Ports:
sys_clk  in  1  clock, all state on rising edge
sys_rst_n  in  1  asynchronous active-low reset
if_valid  in  1  IF presents an instruction
if_pc  in  PC_WIDTH  PC of presented instruction
if_inst  in  32  presented instruction (RV32 encoding)
id_ready  out  1  stage accepts the IF instruction this cycle
raddr1  out  5  regfile read address, if_inst[19:15]
raddr2  out  5  regfile read address, if_inst[24:20]
rdata1  in  DATA_WIDTH  regfile read data, combinational from raddr1
rdata2  in  DATA_WIDTH  regfile read data, combinational from raddr2
ex_valid, ex_wen, ex_is_load  in  1 each  EX-stage instruction status
ex_waddr  in  5  EX destination register
ex_result  in  DATA_WIDTH  EX ALU result
mem_valid, mem_wen  in  1 each  MEM-stage instruction status
mem_waddr  in  5  MEM destination register
mem_wdata  in  DATA_WIDTH  MEM result (load data for loads)
wb_wen  in  1  WB write enable (same signal as the regfile write enable)
wb_waddr  in  5  WB destination register
wb_wdata  in  DATA_WIDTH  WB write data
flush  in  1  kill the stage contents and the incoming instruction
ex_ready  in  1  EX accepts id_ex_* this cycle
id_ex_valid  out  1  ID/EX register holds a valid instruction
id_ex_pc  out  PC_WIDTH  registered PC
id_ex_inst  out  32  registered instruction
id_ex_rd  out  5  registered if_inst[11:7]
id_ex_op1  out  DATA_WIDTH  registered resolved operand 1
id_ex_op2  out  DATA_WIDTH  registered resolved operand 2
stall_cnt  out  CNT_WIDTH  saturating count of load-use bubbles inserted

Behaviour:
- Reset (sys_rst_n=0, asynchronous):
  - id_ex_valid=0.
  - id_ex_pc, id_ex_inst, id_ex_rd, id_ex_op1, id_ex_op2 and stall_cnt all 0.
  - In-flight content is dropped.
  - The first edge after deassertion behaves as a normal cycle.
- raddr1/raddr2 are purely combinational from if_inst, regardless of if_valid.
- Operand resolution, per operand rs, combinational. Priority, first match wins:
  - rs==0: result 0.
  - ex_valid&ex_wen&ex_waddr==rs: ex_result.
  - mem_valid&mem_wen&mem_waddr==rs: mem_wdata.
  - wb_wen&wb_waddr==rs: wb_wdata. Required because the regfile writes at the edge.
  - Otherwise: rdata.
- hazard = if_valid & ex_valid & ex_is_load & ex_wen & ex_waddr!=0 & (ex_waddr==rs1 | ex_waddr==rs2). Both fields are always treated as used.
- advance = !id_ex_valid | ex_ready.
- id_ready = flush | (advance & !hazard).
- Edge update, in priority order:
  - flush: id_ex_valid<=0; the incoming instruction is consumed and dropped.
  - else advance & hazard: id_ex_valid<=0 (bubble); stall_cnt+=1, saturating at all-ones.
  - else advance: id_ex_valid<=if_valid; the payload registers load the fields and resolved operands.
  - else (EX stalled): all id_ex_* hold unchanged.
- Load-use latency:
  - A dependent instruction leaves ID exactly one cycle later than it would without the hazard.
  - On the retry cycle the load sits in MEM and is forwarded via mem_wdata.
- Payload registers are loaded only when advance & !flush & !hazard & if_valid; otherwise they hold. Data need not be cleared on bubbles.
- Simultaneous flush and hazard: flush wins; stall_cnt is not incremented.

Decomposition:
- Shared package pipe_pkg: REG_ADDR_W=5; field positions RS1_MSB/LSB=19/15, RS2=24/20, RD=11/7; NOP_INST=32'h00000013.
- One sub-module, operand_fwd_mux: the priority bypass mux for one operand, instantiated twice.

Test Plan:
- Regfile-only: x5=0x11 (rdata), no bypass, inst add x3,x5,x0, ex_ready=1 -> next edge id_ex_valid=1, op1=0x11, op2=0.
- Bypass priority: rs1=7, with EX/MEM/WB all writing x7 (0xA/0xB/0xC) -> op1=0xA; drop EX -> 0xB; drop MEM -> 0xC.
- x0 guard: rs1=0 while EX writes x0=0xFF -> op1=0.
- Load-use: lw x4 in EX (ex_is_load=1), ID holds add x6,x4,x4:
  - first cycle -> id_ready=0, id_ex_valid=0, stall_cnt=1;
  - next cycle, mem_wdata=0x55 -> op1=op2=0x55, id_ex_valid=1.
- Backpressure: ex_ready=0 with a valid entry -> id_ready=0 and id_ex_* stable for 3 cycles; ex_ready=1 -> advance.
- Flush/reset: flush during hazard -> id_ex_valid=0, id_ready=1, stall_cnt unchanged; pulse sys_rst_n low mid-stream -> all outputs 0 immediately.
